fxp_requant_sat: RTL and testbench
==================================

Name: fxp_requant_sat

Overview:
Streaming multi-lane requantizer for the fixed-point library.
- Takes LANES signed IN_W-bit accumulators per beat.
- Applies a per-beat arithmetic right shift with a selectable rounding mode, then saturates each lane to signed OUT_W.
- 2-stage valid/ready pipeline between MAC accumulators and the activation/store path.
- Reports per-beat saturation flags and a running saturation-event counter.

Parameters:
LANES, 4, number of parallel lanes per beat
IN_W, 32, signed input width per lane
OUT_W, 8, signed output width per lane (2 <= OUT_W < IN_W)
SHIFT_W, 5, width of shift input
CNT_W, 16, width of saturation-event counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  LANES*IN_W  lane i at [i*IN_W +: IN_W], signed
in_last  in  1  frame marker, passed through with beat
shift  in  SHIFT_W  right-shift amount, sampled with beat
rnd_mode  in  2  rounding mode, sampled with beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W], signed
out_last  out  1  in_last of this beat
sat_flags  out  LANES  bit i set if lane i clipped on this beat
sat_count  out  CNT_W  total lane saturation events since reset/clear
clr_count  in  1  synchronous clear of sat_count

Behaviour:
- Reset (async assert, sync release): all stage valids 0, out_valid 0, out_data 0, out_last 0, sat_flags 0, sat_count 0.
- Pipeline: S1 = round+shift (IN_W+1-bit result), S2 = saturate, registered outputs.
- en = !out_valid || out_ready. Both stages advance when en=1 and hold otherwise. in_ready = en (combinational from out_ready, documented path).
- Latency: 2 cycles from accepted beat to out_valid with no backpressure. Throughput is 1 beat/cycle. No beat is lost or duplicated, and order is preserved.
- Bubbles: a stage advancing with no valid beat loads valid=0.
- Effective shift s = min(shift, IN_W-1).
- s=0: value passes unchanged and mode is ignored.
- Rounding modes, with q = x >>> s, rem = x & (2^s-1), half = 2^(s-1):
  - 0 TRUNC: floor(q).
  - 1 HALF_UP: (x + half) >>> s, computed in IN_W+1 bits so no wrap occurs.
  - 2 HALF_EVEN: q+1 if rem > half, or if rem == half and q is odd; else q.
  - 3: reserved, behaves as TRUNC.
- Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sat_flags[i] = 1 iff clamping changed the value.
- sat_count:
  - On each output handshake (out_valid && out_ready), add popcount(sat_flags).
  - Sticks at 2^CNT_W-1 and never wraps.
  - If clr_count is asserted in the same cycle as a handshake, clear wins and that beat's contribution is discarded.
- Reset mid-stream: in-flight beats are dropped and out_valid falls immediately with rst_n low.

Decomposition:
- Package fxp_pkg:
  - rnd_mode_e (RND_TRUNC=0, RND_HALF_UP=1, RND_HALF_EVEN=2, RND_RSVD=3).
  - Function sat_bounds(OUT_W).
  - Function popcount.
- Sub-module fxp_round_shift: one lane, combinational. Inputs are IN_W data, s, and mode; output is IN_W+1-bit rounded value. Instantiated LANES times in S1. Saturation is done inline in S2.

Test Plan:
- Clipping, shift=0, TRUNC, out_ready=1: lanes {0,200,-300,50} -> out {0,127,-128,50} two cycles later; sat_flags=4'b0110; sat_count=2.
- HALF_UP, shift=2: lanes {6,5,-6,-7} -> {2,1,-1,-2}, sat_flags=0.
- HALF_EVEN, shift=2: lanes {6,10,-6,14} -> {2,2,-2,4}. Same values with TRUNC -> {1,2,-2,3}.
- Wide input, HALF_UP, shift=1: lane 2147483647 -> 127 with flag set, no wrap. Any shift value >= 32 behaves as 31.
- Backpressure: 5 back-to-back beats with out_ready low for 3 cycles mid-stream.
  - in_ready drops once the pipeline is full.
  - All 5 beats emerge in order with the correct in_last/out_last alignment.
  - out_data is stable while stalled.
- Counter and reset, with CNT_W=3:
  - Two beats, all 4 lanes saturating -> sat_count holds at 7.
  - clr_count asserted on a handshake cycle -> 0.
  - rst_n pulsed while 2 beats are in flight -> out_valid=0, and no stale beat appears after release.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared types and helpers for the fixed-point requantizer.
package fxp_pkg;

   typedef enum logic [1:0] {
      RND_TRUNC     = 2'd0,
      RND_HALF_UP   = 2'd1,
      RND_HALF_EVEN = 2'd2,
      RND_RSVD      = 2'd3
   } rnd_mode_e;

   // Signed clamp range for an out_w-bit two's complement result.
   function automatic void sat_bounds(input int unsigned out_w, output longint lo, output longint hi);
      hi = (longint'(1) << (out_w - 1)) - 1;
      lo = -(longint'(1) << (out_w - 1));
   endfunction

   // Number of set bits; narrower vectors are zero-extended by the caller.
   function automatic int unsigned popcount(input logic [63:0] v);
      int unsigned cnt;
      cnt = 0;
      for (int unsigned i = 0; i < 64; i++) begin
         cnt += 32'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/fxp_round_shift.sv
// One lane of arithmetic right shift with selectable rounding.
// The result is one bit wider than the input so HALF_UP biasing cannot wrap.
module fxp_round_shift
   import fxp_pkg::*;
#(
   parameter int IN_W    = 32,
   parameter int SHIFT_W = 5
) (
   input  logic signed [IN_W-1:0]  x,
   input  logic        [SHIFT_W-1:0] shift,
   input  logic        [1:0]       mode,
   output logic signed [IN_W:0]    y
);

   logic        [31:0] s;
   logic signed [IN_W:0] xe;
   logic signed [IN_W:0] q;
   logic signed [IN_W:0] biased;
   logic        [IN_W:0] one;
   logic        [IN_W:0] mask;
   logic        [IN_W:0] half;
   logic        [IN_W:0] rem;

   // Clamp the shift, derive floor quotient / remainder / half, then pick by mode.
   always_comb begin
      s      = (32'(shift) > 32'(IN_W - 1)) ? 32'(IN_W - 1) : 32'(shift);
      one    = {{IN_W{1'b0}}, 1'b1};
      xe     = {x[IN_W-1], x};
      q      = xe >>> s;
      mask   = (one << s) - one;
      half   = (s == 0) ? '0 : (one << (s - 1));
      rem    = xe & mask;
      biased = xe + $signed(half);
      y      = q;
      if (s != 0) begin
         case (rnd_mode_e'(mode))
            RND_HALF_UP: y = biased >>> s;
            RND_HALF_EVEN: begin
               if ((rem > half) || ((rem == half) && q[0])) begin
                  y = q + $signed(one);
               end
            end
            default: y = q;
         endcase
      end
   end

endmodule

// File: rtl/fxp_requant_sat.sv
// Multi-lane requantizer: S1 round+shift, S2 saturate into registered outputs,
// with per-beat clip flags and a sticky saturation-event counter.
module fxp_requant_sat
   import fxp_pkg::*;
#(
   parameter int LANES   = 4,
   parameter int IN_W    = 32,
   parameter int OUT_W   = 8,
   parameter int SHIFT_W = 5,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_data,
   input  logic                   in_last,
   input  logic [SHIFT_W-1:0]     shift,
   input  logic [1:0]             rnd_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic                   out_last,
   output logic [LANES-1:0]       sat_flags,
   output logic [CNT_W-1:0]       sat_count,
   input  logic                   clr_count
);

   localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

   logic                 en;
   logic                 s1_valid;
   logic                 s1_last;
   logic signed [IN_W:0] rs_y   [LANES];
   logic signed [IN_W:0] s1_val [LANES];
   logic [LANES*OUT_W-1:0] sat_d;
   logic [LANES-1:0]     flags_d;
   longint               lo;
   longint               hi;
   longint               vw;
   logic [63:0]          sum;
   logic [CNT_W-1:0]     cnt_next;

   // Whole pipeline advances together; in_ready is combinational from out_ready.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fxp_round_shift #(
         .IN_W    (IN_W),
         .SHIFT_W (SHIFT_W)
      ) u_rs (
         .x     (in_data[g*IN_W +: IN_W]),
         .shift (shift),
         .mode  (rnd_mode),
         .y     (rs_y[g])
      );
   end

   // Stage 1: capture rounded lanes together with valid and frame marker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) begin
            s1_val[i] <= '0;
         end
      end else if (en) begin
         s1_valid <= in_valid;
         s1_last  <= in_last;
         for (int unsigned i = 0; i < LANES; i++) begin
            s1_val[i] <= rs_y[i];
         end
      end
   end

   // Clamp each stage-1 lane to the signed output range and flag clipping.
   always_comb begin
      sat_bounds(OUT_W, lo, hi);
      sat_d   = '0;
      flags_d = '0;
      vw      = 0;
      for (int unsigned i = 0; i < LANES; i++) begin
         vw = longint'(s1_val[i]);
         if (vw > hi) begin
            sat_d[i*OUT_W +: OUT_W] = {1'b0, {(OUT_W-1){1'b1}}};
            flags_d[i]              = 1'b1;
         end else if (vw < lo) begin
            sat_d[i*OUT_W +: OUT_W] = {1'b1, {(OUT_W-1){1'b0}}};
            flags_d[i]              = 1'b1;
         end else begin
            sat_d[i*OUT_W +: OUT_W] = s1_val[i][OUT_W-1:0];
         end
      end
   end

   // Stage 2: registered outputs; bubbles carry no flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         sat_flags <= '0;
      end else if (en) begin
         out_valid <= s1_valid;
         out_data  <= sat_d;
         out_last  <= s1_last;
         sat_flags <= s1_valid ? flags_d : '0;
      end
   end

   // Saturating add of this beat's clip count.
   always_comb begin
      sum      = 64'(sat_count) + 64'(popcount(64'(sat_flags)));
      cnt_next = (sum > CNT_MAX) ? '1 : sum[CNT_W-1:0];
   end

   // Event counter: clear has priority over a same-cycle handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (clr_count) begin
         sat_count <= '0;
      end else if (out_valid && out_ready) begin
         sat_count <= cnt_next;
      end
   end

endmodule

// File: tb/tb_fxp_requant_sat.sv
// Directed bench for fxp_requant_sat (4 lanes, 32->8 bit, 6-bit shift, 3-bit counter).
module tb_fxp_requant_sat;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_last;
   logic [5:0]   shift;
   logic [1:0]   rnd_mode;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic         out_last;
   logic [3:0]   sat_flags;
   logic [2:0]   sat_count;
   logic         clr_count;

   int checks = 0;
   int errors = 0;

   fxp_requant_sat #(
      .LANES   (4),
      .IN_W    (32),
      .OUT_W   (8),
      .SHIFT_W (6),
      .CNT_W   (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .shift     (shift),
      .rnd_mode  (rnd_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .sat_flags (sat_flags),
      .sat_count (sat_count),
      .clr_count (clr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
      return {d, c, b, a};
   endfunction

   function automatic logic [31:0] pk8(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat with out_ready high and wait (bounded) for it to appear.
   task automatic run_beat(input logic [127:0] d, input logic [5:0] sh, input logic [1:0] m,
                           input logic l, output logic ok, output int lat);
      in_valid  = 1'b1;
      in_data   = d;
      shift     = sh;
      rnd_mode  = m;
      in_last   = l;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      ok = out_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      shift = '0; rnd_mode = '0; out_ready = 1'b1; clr_count = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0) begin
         errors++; $display("FAIL reset_valid: out_valid=%b out_last=%b required 0 0", out_valid, out_last);
      end
      checks++;
      if (out_data !== 32'h0 || sat_flags !== 4'h0 || sat_count !== 3'd0) begin
         errors++; $display("FAIL reset_data: data=%h flags=%b count=%0d required 0", out_data, sat_flags, sat_count);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_clip();
      logic ok; int lat;
      run_beat(pk(0, 200, -300, 50), 6'd0, 2'd0, 1'b1, ok, lat);
      checks++;
      if (ok !== 1'b1 || lat != 2) begin
         errors++; $display("FAIL clip_latency: valid=%b latency=%0d required 1 2", ok, lat);
      end
      checks++;
      if (out_data !== pk8(0, 127, -128, 50) || out_last !== 1'b1) begin
         errors++; $display("FAIL clip_data: got %h last %b required %h last 1", out_data, out_last, pk8(0, 127, -128, 50));
      end
      checks++;
      if (sat_flags !== 4'b0110) begin
         errors++; $display("FAIL clip_flags: got %b required 0110", sat_flags);
      end
      tick();
      checks++;
      if (sat_count !== 3'd2 || out_valid !== 1'b0) begin
         errors++; $display("FAIL clip_count: count=%0d valid=%b required 2 0", sat_count, out_valid);
      end
   endtask

   task automatic test_half_up();
      logic ok; int lat;
      run_beat(pk(6, 5, -6, -7), 6'd2, 2'd1, 1'b0, ok, lat);
      checks++;
      if (ok !== 1'b1 || out_data !== pk8(2, 1, -1, -2) || sat_flags !== 4'h0 || out_last !== 1'b0) begin
         errors++; $display("FAIL half_up: got %h flags %b last %b required %h 0000 0", out_data, sat_flags, out_last, pk8(2, 1, -1, -2));
      end
      tick();
      checks++;
      if (sat_count !== 3'd2) begin
         errors++; $display("FAIL half_up_count: got %0d required 2", sat_count);
      end
   endtask

   task automatic test_half_even();
      logic ok; int lat;
      run_beat(pk(6, 10, -6, 14), 6'd2, 2'd2, 1'b0, ok, lat);
      checks++;
      if (ok !== 1'b1 || out_data !== pk8(2, 2, -2, 4)) begin
         errors++; $display("FAIL half_even: got %h required %h", out_data, pk8(2, 2, -2, 4));
      end
      tick();
      run_beat(pk(6, 10, -6, 14), 6'd2, 2'd0, 1'b0, ok, lat);
      checks++;
      if (ok !== 1'b1 || out_data !== pk8(1, 2, -2, 3)) begin
         errors++; $display("FAIL trunc: got %h required %h", out_data, pk8(1, 2, -2, 3));
      end
      tick();
      run_beat(pk(6, 10, -6, 14), 6'd2, 2'd3, 1'b0, ok, lat);
      checks++;
      if (ok !== 1'b1 || out_data !== pk8(1, 2, -2, 3)) begin
         errors++; $display("FAIL reserved_mode: got %h required %h", out_data, pk8(1, 2, -2, 3));
      end
      tick();
      run_beat(pk(-7, 7, 3, -3), 6'd0, 2'd1, 1'b0, ok, lat);
      checks++;
      if (ok !== 1'b1 || out_data !== pk8(-7, 7, 3, -3)) begin
         errors++; $display("FAIL shift0_passthru: got %h required %h", out_data, pk8(-7, 7, 3, -3));
      end
      tick();
   endtask

   task automatic test_wide();
      logic ok; int lat;
      run_beat(pk(0, 0, 2147483647, 0), 6'd1, 2'd1, 1'b0, ok, lat);
      checks++;
      if (ok !== 1'b1 || out_data !== pk8(0, 0, 127, 0) || sat_flags !== 4'b0100) begin
         errors++; $display("FAIL wide_half_up: got %h flags %b required %h 0100", out_data, sat_flags, pk8(0, 0, 127, 0));
      end
      tick();
      checks++;
      if (sat_count !== 3'd3) begin
         errors++; $display("FAIL wide_count: got %0d required 3", sat_count);
      end
      run_beat(pk(32'h40000000, 2147483647, int'(32'h80000000), -1), 6'd63, 2'd1, 1'b0, ok, lat);
      checks++;
      if (ok !== 1'b1 || out_data !== pk8(1, 1, -1, 0) || sat_flags !== 4'h0) begin
         errors++; $display("FAIL shift_clamp_half_up: got %h flags %b required %h 0000", out_data, sat_flags, pk8(1, 1, -1, 0));
      end
      tick();
      run_beat(pk(32'h40000000, 2147483647, int'(32'h80000000), -1), 6'd40, 2'd0, 1'b0, ok, lat);
      checks++;
      if (ok !== 1'b1 || out_data !== pk8(0, 0, -1, -1) || sat_flags !== 4'h0) begin
         errors++; $display("FAIL shift_clamp_trunc: got %h flags %b required %h 0000", out_data, sat_flags, pk8(0, 0, -1, -1));
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] got_d[$];
      logic        got_l[$];
      int          sent = 0;
      bit          fire = 0;
      bit          stall_seen = 0;
      bit          rdy_bad = 0;
      logic        prev_v = 1'b0;
      logic        prev_r = 1'b1;
      logic [31:0] prev_d = '0;
      logic        prev_l = 1'b0;
      for (int cyc = 0; cyc < 40 && got_d.size() < 5; cyc++) begin
         if (fire) sent++;
         if (sent < 5) begin
            in_valid = 1'b1;
            in_data  = pk(sent, sent + 1, -sent, 100 + sent);
            in_last  = sent[0];
         end else begin
            in_valid = 1'b0;
         end
         shift     = '0;
         rnd_mode  = '0;
         out_ready = !(cyc >= 3 && cyc <= 5);
         #1;
         if (prev_v && !prev_r) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
               errors++; $display("FAIL stall_hold: valid=%b data=%h last=%b required 1 %h %b", out_valid, out_data, out_last, prev_d, prev_l);
            end
         end
         if (in_ready !== !(out_valid && !out_ready)) rdy_bad = 1;
         if (in_valid && !in_ready) stall_seen = 1;
         fire = in_valid && in_ready;
         if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
         end
         prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_l = out_last;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got_d.size() != 5) begin
         errors++; $display("FAIL b2b_count: got %0d beats required 5", got_d.size());
      end
      checks++;
      if (stall_seen !== 1'b1 || rdy_bad !== 1'b0) begin
         errors++; $display("FAIL b2b_in_ready: drop_seen=%b wrong_ready=%b required 1 0", stall_seen, rdy_bad);
      end
      for (int k = 0; k < got_d.size(); k++) begin
         checks++;
         if (got_d[k] !== pk8(k, k + 1, -k, 100 + k) || got_l[k] !== k[0]) begin
            errors++; $display("FAIL b2b_beat%0d: got %h last %b required %h last %b", k, got_d[k], got_l[k], pk8(k, k + 1, -k, 100 + k), k[0]);
         end
      end
   endtask

   task automatic test_counter();
      logic ok; int lat;
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      checks++;
      if (sat_count !== 3'd0) begin
         errors++; $display("FAIL cnt_clear_idle: got %0d required 0", sat_count);
      end
      run_beat(pk(1000, -1000, 500, -500), 6'd0, 2'd0, 1'b0, ok, lat);
      checks++;
      if (ok !== 1'b1 || out_data !== pk8(127, -128, 127, -128) || sat_flags !== 4'hF) begin
         errors++; $display("FAIL cnt_beat: got %h flags %b required %h 1111", out_data, sat_flags, pk8(127, -128, 127, -128));
      end
      tick();
      checks++;
      if (sat_count !== 3'd4) begin
         errors++; $display("FAIL cnt_first: got %0d required 4", sat_count);
      end
      run_beat(pk(1000, -1000, 500, -500), 6'd0, 2'd0, 1'b0, ok, lat);
      tick();
      checks++;
      if (sat_count !== 3'd7) begin
         errors++; $display("FAIL cnt_sticky: got %0d required 7", sat_count);
      end
      run_beat(pk(1000, -1000, 500, -500), 6'd0, 2'd0, 1'b0, ok, lat);
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      checks++;
      if (sat_count !== 3'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL cnt_clear_wins: count=%0d valid=%b required 0 0", sat_count, out_valid);
      end
   endtask

   task automatic test_reset_midstream();
      logic ok; int lat;
      bit   stale = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1; in_last = 1'b0; shift = '0; rnd_mode = '0;
      in_data   = pk(1000, 1, 2, 3);
      tick();
      in_data   = pk(4, 5, 6, 7);
      tick();
      in_data   = pk(8, 9, 10, 11);
      tick();
      in_valid  = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== pk8(4, 5, 6, 7) || sat_count !== 3'd1) begin
         errors++; $display("FAIL mid_prefill: valid=%b data=%h count=%0d required 1 %h 1", out_valid, out_data, sat_count, pk8(4, 5, 6, 7));
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || sat_count !== 3'd0 || sat_flags !== 4'h0) begin
         errors++; $display("FAIL mid_reset: valid=%b data=%h count=%0d flags=%b required all 0", out_valid, out_data, sat_count, sat_flags);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (out_valid !== 1'b0) stale = 1;
      end
      checks++;
      if (stale !== 1'b0) begin
         errors++; $display("FAIL mid_stale: stale beat seen=%b required 0", stale);
      end
      run_beat(pk(-1, 1, -2, 2), 6'd0, 2'd0, 1'b1, ok, lat);
      checks++;
      if (ok !== 1'b1 || lat != 2 || out_data !== pk8(-1, 1, -2, 2) || out_last !== 1'b1) begin
         errors++; $display("FAIL mid_recover: valid=%b lat=%0d data=%h required 1 2 %h", ok, lat, out_data, pk8(-1, 1, -2, 2));
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_clip();
      test_half_up();
      test_half_even();
      test_wide();
      test_back_to_back();
      test_counter();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
